rob_nway: RTL
=============

// Module: rob_nway
// PURPOSE
//  Parametrised N-way reorder buffer, the successor to the fixed-width ROB.
//  - Buffers up to N_ENTRIES in-flight instructions in program order.
//  - Dispatch and completion are W-wide. Retirement is in order, up to W per cycle.
//  - Occupancy is count-based (no empty-flag ambiguity). Each entry has a valid bit.
//  - New: full flush on a retiring mispredict, per-way dispatch accept, free-slot count, sticky halt.
// PARAMETERS
//  N_ENTRIES  32  ROB depth; power of two, >= 2*W
//  W          2   superscalar ways (dispatch, complete, retire)
//  PRF_BITS   6   physical register index width
//  XLEN       32  data/PC width
//  IDXW       $clog2(N_ENTRIES)    (localparam) entry index width
//  CNTW       $clog2(N_ENTRIES+1)  (localparam) count width
// PORTS
//  clock          in   1          rising-edge clock
//  reset          in   1          asynchronous, active-low reset
//  disp_valid     in   W          way i presents an instruction
//  disp_t_idx     in   W*PRF_BITS new physical dest
//  disp_told_idx  in   W*PRF_BITS previous physical mapping of dest
//  disp_ar_idx    in   W*5        architectural dest
//  disp_halt      in   W          instruction is a halt
//  disp_npc       in   W*XLEN     PC+4 of instruction
//  disp_ready     out  W          way i accepted this cycle (comb)
//  disp_idx       out  W*IDXW     entry assigned to way i (valid when disp_ready[i])
//  cmpl_valid     in   W          completion on way i
//  cmpl_idx       in   W*IDXW     entry being completed
//  cmpl_value     in   W*XLEN     result value
//  cmpl_mispred   in   W          branch resolved mispredicted
//  cmpl_target    in   W*XLEN     correct target PC
//  ret_valid      out  W          retire slot i valid (comb, lowest slots first)
//  ret_t_idx/ret_told_idx/ret_ar_idx/ret_value/ret_halt/ret_npc  out  per-way  retired entry fields
//  squash         out  1          flush the pipeline (comb, same cycle as the mispredict retires)
//  squash_pc      out  XLEN       redirect PC; 0 when squash=0
//  free_count     out  CNTW       N_ENTRIES - occupancy (registered state)
//  halted         out  1          sticky once a halt retires
// BEHAVIOUR
//  Reset (reset=0, async): head=tail=0, count=0, all entry valid/complete=0, halted=0.
//   Consequently all outputs are 0, except free_count=N_ENTRIES.
//  Retire: slot 0 retires if head is valid and complete.
//   Slot i>0 retires if slot i-1 retired, entry head+i is valid and complete,
//   and entry head+i-1 is neither mispred nor halt. Max W retires, never beyond count.
//  Squash: if any retiring entry has mispred=1, assert squash with that entry's target.
//   Next cycle: every entry invalidated, head=tail=0, count=0.
//   In a squash cycle all disp_ready=0 and all completions are dropped.
//  Halt: on halt retirement, halted=1 next cycle. After that, retire_en=0 and disp_ready=0
//   until reset.
//  Dispatch: ways are accepted in order.
//   Way i is accepted iff disp_valid[0..i] are all 1 and i+1 <= N_ENTRIES - count + n_retire
//   (same-cycle retires free slots).
//   A valid way above an invalid way is rejected.
//   Accepted way i gets entry tail+i (mod N_ENTRIES), which is written valid=1, complete=0, mispred=0.
//  Complete: sets complete, value, mispred and target on cmpl_idx.
//   Ignored if the entry is invalid or is being retired this cycle.
//   Completions on distinct ways to the same idx: the higher way wins.
//  Pointers: head += n_retire and tail += n_accept, both mod N_ENTRIES (natural wrap, IDXW bits).
//   count += n_accept - n_retire.
//   Full at count==N_ENTRIES: head==tail is then unambiguous via count.
//  Latency: an entry completed in cycle t is retirable in cycle t+1 at the earliest.
//   A dispatched entry is not retirable before cycle t+2.
//  Simultaneous full+retire: the freed slots are reusable in the same cycle.
// STRUCTURE
//  - Shared package (sys_defs): ROB_ENTRY struct (valid, complete, mispred, halt,
//    t_idx, told_idx, ar_idx, value, npc, target) and the N_ROB_ENTRIES / SUPERSCALAR_WAYS defaults.
//  - One sub-module, rob_retire_sel: combinational W-slot retire-enable chain
//    plus n_retire popcount and squash select.
//  - Entry array, pointers and count live in one always_ff with async active-low reset.
// TESTING
//  1 Reset mid-run (6 entries held): reset=0 asynchronously -> free_count=N, ret_valid=0, squash=0 within the same cycle.
//  2 Fill: W=2, N=8, dispatch 2/cycle with no completes -> disp_idx 0..7 over 4 cycles; 5th cycle disp_ready=00, free_count=0.
//  3 Full+retire: full ROB, complete entries 0,1; next cycle dispatch 2 -> ret_valid=11 and disp_ready=11, disp_idx={1,0} (wrap), free_count stays 0.
//  4 Mispredict: entries 0..5 valid; complete 0 (mispred, target 0x100) and 1 -> only slot 0 retires, squash=1, squash_pc=0x100; next cycle free_count=N, a completion to idx 3 is ignored.
//  5 Halt: retire a halt in slot 0 while slot 1 is complete -> ret_valid=01, halted=1 next cycle, disp_ready=0 afterwards.
//  6 Gap: disp_valid=10 -> disp_ready=00 and tail unchanged; out-of-order completes 3,2,1,0 -> retires 0,1 then 2,3 in consecutive cycles.

Source files
------------

// File: rtl/sys_defs.sv
// Shared ROB definitions: default sizing and the per-entry record.
// Entry field widths follow the package defaults; rob_nway's PRF_BITS/XLEN must match them.
package sys_defs;
  localparam int N_ROB_ENTRIES    = 32;
  localparam int SUPERSCALAR_WAYS = 2;
  localparam int DEF_PRF_BITS     = 6;
  localparam int DEF_XLEN         = 32;

  typedef struct packed {
    logic                    valid;
    logic                    complete;
    logic                    mispred;
    logic                    halt;
    logic [DEF_PRF_BITS-1:0] t_idx;
    logic [DEF_PRF_BITS-1:0] told_idx;
    logic [4:0]              ar_idx;
    logic [DEF_XLEN-1:0]     value;
    logic [DEF_XLEN-1:0]     npc;
    logic [DEF_XLEN-1:0]     target;
  } ROB_ENTRY;
endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire-enable chain over the W head slots, with retire count and squash select.
module rob_retire_sel #(
  parameter int W    = 2,
  parameter int CNTW = 6,
  parameter int XLEN = 32
) (
  input  logic              retire_en_i,
  input  logic [CNTW-1:0]   count_i,
  input  logic [W-1:0]      valid_i,
  input  logic [W-1:0]      complete_i,
  input  logic [W-1:0]      mispred_i,
  input  logic [W-1:0]      halt_i,
  input  logic [W*XLEN-1:0] target_i,
  output logic [W-1:0]      ret_en_o,
  output logic [CNTW-1:0]   n_retire_o,
  output logic              squash_o,
  output logic [XLEN-1:0]   squash_pc_o
);
  logic chain;

  // A mispredict or halt ends the chain after itself, so at most one squash source exists.
  always_comb begin
    ret_en_o    = '0;
    n_retire_o  = '0;
    squash_o    = 1'b0;
    squash_pc_o = '0;
    chain       = retire_en_i;
    for (int i = 0; i < W; i++) begin
      chain       = chain && valid_i[i] && complete_i[i] && (CNTW'(i) < count_i);
      ret_en_o[i] = chain;
      if (chain) begin
        n_retire_o = n_retire_o + CNTW'(1);
        if (mispred_i[i]) begin
          squash_o    = 1'b1;
          squash_pc_o = target_i[i*XLEN +: XLEN];
        end
      end
      chain = chain && !mispred_i[i] && !halt_i[i];
    end
  end
endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: W-wide dispatch/complete, in-order retire of up to W per cycle,
// full flush on a retiring mispredict and a sticky halt.
module rob_nway
  import sys_defs::*;
#(
  parameter int N_ENTRIES = N_ROB_ENTRIES,
  parameter int W         = SUPERSCALAR_WAYS,
  parameter int PRF_BITS  = DEF_PRF_BITS,
  parameter int XLEN      = DEF_XLEN
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [W-1:0]                   disp_valid,
  input  logic [W*PRF_BITS-1:0]          disp_t_idx,
  input  logic [W*PRF_BITS-1:0]          disp_told_idx,
  input  logic [W*5-1:0]                 disp_ar_idx,
  input  logic [W-1:0]                   disp_halt,
  input  logic [W*XLEN-1:0]              disp_npc,
  output logic [W-1:0]                   disp_ready,
  output logic [W*$clog2(N_ENTRIES)-1:0] disp_idx,
  input  logic [W-1:0]                   cmpl_valid,
  input  logic [W*$clog2(N_ENTRIES)-1:0] cmpl_idx,
  input  logic [W*XLEN-1:0]              cmpl_value,
  input  logic [W-1:0]                   cmpl_mispred,
  input  logic [W*XLEN-1:0]              cmpl_target,
  output logic [W-1:0]                   ret_valid,
  output logic [W*PRF_BITS-1:0]          ret_t_idx,
  output logic [W*PRF_BITS-1:0]          ret_told_idx,
  output logic [W*5-1:0]                 ret_ar_idx,
  output logic [W*XLEN-1:0]              ret_value,
  output logic [W-1:0]                   ret_halt,
  output logic [W*XLEN-1:0]              ret_npc,
  output logic                           squash,
  output logic [XLEN-1:0]                squash_pc,
  output logic [$clog2(N_ENTRIES+1)-1:0] free_count,
  output logic                           halted
);
  localparam int IDXW = $clog2(N_ENTRIES);
  localparam int CNTW = $clog2(N_ENTRIES+1);

  ROB_ENTRY        rob_q [N_ENTRIES];
  logic [IDXW-1:0] head_q, tail_q;
  logic [CNTW-1:0] count_q;
  logic            halted_q;

  ROB_ENTRY          slot [W];
  logic [IDXW-1:0]   slot_idx [W];
  logic [W-1:0]      s_valid, s_complete, s_mispred, s_halt, ret_en;
  logic [W*XLEN-1:0] s_target;
  logic [CNTW-1:0]   n_retire, n_accept, free_after;
  logic [N_ENTRIES-1:0] retiring;
  logic              acc_ok;

  always_comb begin
    s_valid    = '0;
    s_complete = '0;
    s_mispred  = '0;
    s_halt     = '0;
    s_target   = '0;
    for (int i = 0; i < W; i++) begin
      slot_idx[i]                = head_q + IDXW'(i);
      slot[i]                    = rob_q[slot_idx[i]];
      s_valid[i]                 = slot[i].valid;
      s_complete[i]              = slot[i].complete;
      s_mispred[i]               = slot[i].mispred;
      s_halt[i]                  = slot[i].halt;
      s_target[i*XLEN +: XLEN]   = slot[i].target;
    end
  end

  rob_retire_sel #(.W(W), .CNTW(CNTW), .XLEN(XLEN)) u_retire_sel (
    .retire_en_i (!halted_q),
    .count_i     (count_q),
    .valid_i     (s_valid),
    .complete_i  (s_complete),
    .mispred_i   (s_mispred),
    .halt_i      (s_halt),
    .target_i    (s_target),
    .ret_en_o    (ret_en),
    .n_retire_o  (n_retire),
    .squash_o    (squash),
    .squash_pc_o (squash_pc)
  );

  always_comb begin
    retiring     = '0;
    ret_valid    = ret_en;
    ret_t_idx    = '0;
    ret_told_idx = '0;
    ret_ar_idx   = '0;
    ret_value    = '0;
    ret_halt     = '0;
    ret_npc      = '0;
    for (int i = 0; i < W; i++) begin
      if (ret_en[i]) begin
        retiring[slot_idx[i]]              = 1'b1;
        ret_t_idx[i*PRF_BITS +: PRF_BITS]    = slot[i].t_idx;
        ret_told_idx[i*PRF_BITS +: PRF_BITS] = slot[i].told_idx;
        ret_ar_idx[i*5 +: 5]                 = slot[i].ar_idx;
        ret_value[i*XLEN +: XLEN]            = slot[i].value;
        ret_halt[i]                          = slot[i].halt;
        ret_npc[i*XLEN +: XLEN]              = slot[i].npc;
      end
    end
  end

  // Slots freed by this cycle's retires are offered to dispatch in the same cycle.
  always_comb begin
    free_after = CNTW'(N_ENTRIES) - count_q + n_retire;
    disp_ready = '0;
    disp_idx   = '0;
    n_accept   = '0;
    acc_ok     = !squash && !halted_q;
    for (int i = 0; i < W; i++) begin
      acc_ok        = acc_ok && disp_valid[i] && (CNTW'(i + 1) <= free_after);
      disp_ready[i] = acc_ok;
      if (acc_ok) begin
        disp_idx[i*IDXW +: IDXW] = tail_q + IDXW'(i);
        n_accept                 = n_accept + CNTW'(1);
      end
    end
  end

  assign free_count = CNTW'(N_ENTRIES) - count_q;
  assign halted     = halted_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < N_ENTRIES; e++) rob_q[e] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else if (squash) begin
      for (int e = 0; e < N_ENTRIES; e++) rob_q[e] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= halted_q | (|(ret_en & s_halt));
    end else begin
      halted_q <= halted_q | (|(ret_en & s_halt));
      for (int e = 0; e < N_ENTRIES; e++) begin
        if (retiring[e]) begin
          rob_q[e].valid    <= 1'b0;
          rob_q[e].complete <= 1'b0;
        end
      end
      // Later ways overwrite earlier ones, so the highest way wins on a shared index.
      for (int i = 0; i < W; i++) begin
        if (cmpl_valid[i] && rob_q[cmpl_idx[i*IDXW +: IDXW]].valid &&
            !retiring[cmpl_idx[i*IDXW +: IDXW]]) begin
          rob_q[cmpl_idx[i*IDXW +: IDXW]].complete <= 1'b1;
          rob_q[cmpl_idx[i*IDXW +: IDXW]].value    <= cmpl_value[i*XLEN +: XLEN];
          rob_q[cmpl_idx[i*IDXW +: IDXW]].mispred  <= cmpl_mispred[i];
          rob_q[cmpl_idx[i*IDXW +: IDXW]].target   <= cmpl_target[i*XLEN +: XLEN];
        end
      end
      for (int i = 0; i < W; i++) begin
        if (disp_ready[i]) begin
          rob_q[tail_q + IDXW'(i)] <= '{valid:    1'b1,
                                       complete: 1'b0,
                                       mispred:  1'b0,
                                       halt:     disp_halt[i],
                                       t_idx:    disp_t_idx[i*PRF_BITS +: PRF_BITS],
                                       told_idx: disp_told_idx[i*PRF_BITS +: PRF_BITS],
                                       ar_idx:   disp_ar_idx[i*5 +: 5],
                                       value:    '0,
                                       npc:      disp_npc[i*XLEN +: XLEN],
                                       target:   '0};
        end
      end
      head_q  <= head_q + IDXW'(n_retire);
      tail_q  <= tail_q + IDXW'(n_accept);
      count_q <= count_q + n_accept - n_retire;
    end
  end
endmodule
